// File: rtl/io_pad_gpio_pkg.sv
// Shared types and default constants for the single-pin GPIO pad controller.
package io_pad_gpio_pkg;

  typedef enum logic [1:0] {
    ST_LO  = 2'd0,
    CHK_HI = 2'd1,
    ST_HI  = 2'd2,
    CHK_LO = 2'd3
  } deb_state_e;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_DEB_W       = 8;

  function automatic logic state_is_high(input deb_state_e st);
    return (st == ST_HI) || (st == CHK_LO);
  endfunction

endpackage

// File: rtl/io_pad_gpio_sync.sv
// N-stage flop synchroniser for the asynchronous pad return; resets to 0.
module io_pad_gpio_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;
  logic [STAGES-1:0] ff_d;

  always_comb begin
    ff_d = {ff_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= '0;
    end else begin
      ff_q <= ff_d;
    end
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/io_pad_gpio_ctrl.sv
// Core-side controller for one bidirectional GPIO pad: registered drive path,
// synchronised/debounced input with edge pulses and sticky irq.
// Optional open-drain mode enabled by defining IO_PAD_GPIO_OPEN_DRAIN_EN.
module io_pad_gpio_ctrl
  import io_pad_gpio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned DEB_W       = DEF_DEB_W,
  parameter logic        RESET_OUT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             p2c,
  output logic             c2p,
  output logic             c2p_en,
  input  logic             dout,
  input  logic             oe,
`ifdef IO_PAD_GPIO_OPEN_DRAIN_EN
  input  logic             od,
`endif
  input  logic [DEB_W-1:0] deb_cycles,
  output logic             din,
  output logic             din_rise,
  output logic             din_fall,
  input  logic             irq_en_rise,
  input  logic             irq_en_fall,
  input  logic             irq_clr,
  output logic             irq
);

  localparam logic [DEB_W-1:0] CNT_ONE = 1;

  logic       c2p_q, c2p_d;
  logic       c2p_en_q, c2p_en_d;
  logic       s;
  deb_state_e state_q, state_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;
  logic       irq_q, irq_d;
  logic       din_cur, din_next;

  always_comb begin
`ifdef IO_PAD_GPIO_OPEN_DRAIN_EN
    // Open-drain: never drive high, release the pad to signal a 1.
    c2p_d    = od ? 1'b0 : dout;
    c2p_en_d = od ? (oe & ~dout) : oe;
`else
    c2p_d    = dout;
    c2p_en_d = oe;
`endif
  end

  io_pad_gpio_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (p2c),
    .q    (s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LO: begin
        if (s) begin
          if (deb_cycles == '0) begin
            state_d = ST_HI;
          end else begin
            state_d = CHK_HI;
            cnt_d   = CNT_ONE;
          end
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else if (cnt_q >= deb_cycles) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HI: begin
        if (!s) begin
          if (deb_cycles == '0) begin
            state_d = ST_LO;
          end else begin
            state_d = CHK_LO;
            cnt_d   = CNT_ONE;
          end
        end
      end
      CHK_LO: begin
        if (s) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else if (cnt_q >= deb_cycles) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LO;
        cnt_d   = '0;
      end
    endcase

    // Pulses are registered alongside the state so they coincide with din.
    din_cur  = state_is_high(state_q);
    din_next = state_is_high(state_d);
    rise_d   = din_next & ~din_cur;
    fall_d   = ~din_next & din_cur;

    if ((rise_q & irq_en_rise) | (fall_q & irq_en_fall)) begin
      irq_d = 1'b1;
    end else if (irq_clr) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c2p_q    <= RESET_OUT;
      c2p_en_q <= 1'b0;
      state_q  <= ST_LO;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      c2p_q    <= c2p_d;
      c2p_en_q <= c2p_en_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      irq_q    <= irq_d;
    end
  end

  assign c2p      = c2p_q;
  assign c2p_en   = c2p_en_q;
  assign din      = din_cur;
  assign din_rise = rise_q;
  assign din_fall = fall_q;
  assign irq      = irq_q;

endmodule

// File: doc/io_pad_gpio_ctrl.md
Name: io_pad_gpio_ctrl

Overview:
- Core-side GPIO controller for one bidirectional pad; connects directly to a bidirectional IO pad cell (ports pad/c2p/c2p_en/p2c).
- Registers the core's drive value and enable into c2p/c2p_en.
- Synchronises and debounces the pad's p2c return into a clean core-level din, with edge pulses and a sticky interrupt.
- One instance per GPIO pin, between the pad ring and the core register file.

Parameters:
- SYNC_STAGES, 2, flops in p2c synchroniser chain; legal range 2..4.
- DEB_W, 8, width of debounce threshold and counter.
- RESET_OUT, 1'b0, reset value of c2p.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- p2c  input  1  pad-to-core value from pad cell; asynchronous to clk.
- c2p  output  1  core-to-pad drive value to pad cell.
- c2p_en  output  1  pad output enable to pad cell; 1 = drive.
- dout  input  1  core requested output value.
- oe  input  1  core requested output enable.
- deb_cycles  input  DEB_W  debounce threshold N; quasi-static, sampled live.
- din  output  1  debounced input level.
- din_rise  output  1  one-cycle pulse when din goes 0->1.
- din_fall  output  1  one-cycle pulse when din goes 1->0.
- irq_en_rise  input  1  enables rise events into irq.
- irq_en_fall  input  1  enables fall events into irq.
- irq_clr  input  1  clears irq pending.
- irq  output  1  sticky interrupt pending.

Behaviour:
- Reset: clock is single; rst_n is asynchronous active-low. During reset: c2p=RESET_OUT, c2p_en=0, din=0, din_rise=0, din_fall=0, irq=0, sync chain=0, FSM=ST_LO, cnt=0.
- Output path:
  - c2p <= dout and c2p_en <= oe on every clk edge; latency is 1 cycle.
  - No combinational path from any input to c2p/c2p_en.
- Sync path: p2c passes through a SYNC_STAGES flop chain; s is the last stage. s reflects a p2c change after SYNC_STAGES edges.
- Debounce FSM states: ST_LO, CHK_HI, ST_HI, CHK_LO. din=1 in ST_HI and CHK_LO, else 0 (decoded from registered state).
- ST_LO:
  - s=1 and N=0 -> ST_HI.
  - s=1 and N>0 -> CHK_HI with cnt=1.
  - Otherwise stay.
- CHK_HI:
  - s=0 -> ST_LO with cnt=0 (glitch rejected, no pulse).
  - s=1 and cnt>=N -> ST_HI with cnt=0.
  - Otherwise cnt++.
- ST_HI and CHK_LO mirror ST_LO and CHK_HI with polarities swapped.
- Latency: din changes N+1 edges after s changes, provided s stays stable.
- Threshold changes: cnt compares with >=, so lowering deb_cycles mid-check completes on the next edge. cnt saturates at all-ones and never wraps.
- Edges: din_rise/din_fall are asserted in the first cycle din shows its new value; never both in the same cycle.
- irq:
  - Set when (din_rise & irq_en_rise) | (din_fall & irq_en_fall).
  - Cleared by irq_clr.
  - Set has priority over a simultaneous clear.
  - Enables are sampled in the cycle of the pulse.
- Reset mid-check returns to ST_LO with din=0, discarding any pending transition. If p2c=1 after reset, din rises after the normal latency and produces din_rise.

Optional Feature:
- Macro: IO_PAD_GPIO_OPEN_DRAIN_EN.
- Defined: adds input port od (1 bit).
  - When od=1: c2p <= 0 and c2p_en <= oe & ~dout, so the pad only pulls low and releases for 1.
  - When od=0: push-pull as above.
  - Same 1-cycle latency.
- Undefined: no od port; push-pull only.

Decomposition:
- Package io_pad_gpio_pkg:
  - FSM state enum (ST_LO, CHK_HI, ST_HI, CHK_LO).
  - Default constants for SYNC_STAGES and DEB_W.
- Sub-module io_pad_gpio_sync: parameterised N-stage flop synchroniser, async active-low reset to 0. It is the only flop chain that samples p2c.

Test Plan:
- Reset, then dout=1, oe=1 at cycle 0 -> c2p=1, c2p_en=1 from cycle 1; reset values (c2p=0, c2p_en=0, din=0, irq=0) hold while rst_n=0.
- SYNC_STAGES=2, deb_cycles=3, p2c 0->1 held -> din rises exactly 2+4=6 edges after the p2c change; din_rise high for 1 cycle.
- deb_cycles=3, p2c high pulse of 2 clk cycles -> din stays 0, no din_rise, irq stays 0.
- deb_cycles=0, p2c toggles 1 then 0 with 10-cycle spacing -> din follows s with 1-edge latency; din_rise and din_fall each pulse once.
- irq_en_fall=1, din falls in the same cycle as irq_clr=1 -> irq=1 next cycle; a later irq_clr alone -> irq=0.
- IO_PAD_GPIO_OPEN_DRAIN_EN defined, od=1, oe=1, dout 0->1 -> c2p=0 throughout; c2p_en goes 1->0 one cycle after dout changes.
